// File: rtl/frogger_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frogger_pkg
// Purpose  : Shared definitions for the Frogger game sequencer: FSM state
//            encodings, default timing constants, score width and a small
//            helper used to size the tick/wait counters.
// Revision : 1.0  initial release
// ============================================================================
package frogger_pkg;

    localparam int c_SCORE_W = 16;
    localparam int c_STATE_W = 3;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_PLAY      = 3'd1;
    localparam logic [2:0] c_ST_DYING     = 3'd2;
    localparam logic [2:0] c_ST_LEVEL_UP  = 3'd3;
    localparam logic [2:0] c_ST_GAME_OVER = 3'd4;

    localparam int c_DEF_TICKS_PER_SEC = 60;
    localparam int c_DEF_TIME_LIMIT    = 30;
    localparam int c_DEF_START_LIVES   = 3;
    localparam int c_DEF_DEATH_TICKS   = 90;
    localparam int c_DEF_LEVELUP_TICKS = 60;
    localparam int c_DEF_MAX_LEVEL     = 7;
    localparam int c_DEF_CROSS_POINTS  = 100;

    // Largest of three integers; the tick and wait counters share one width
    // that must hold the biggest terminal count.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frogger_game_ctrl_btn_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge
// Purpose  : Two-flop synchroniser for an asynchronous push button followed
//            by a registered rising-edge detector. The pulse appears 3 clk
//            after the pin edge and lasts exactly 1 clk.
// Ports    : clk     - system clock
//            reset_n - asynchronous reset, active-low
//            i_btn   - raw button level, asynchronous to clk
//            o_rise  - one-cycle pulse on a synchronised rising edge
// Revision : 1.0  initial release
// ============================================================================
module btn_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic i_btn,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_meta   <= i_btn;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_rise   <= r_sync & ~r_sync_d;
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/frogger_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frogger_game_ctrl
// Purpose  : Game sequencer for the Frogger playfield. Tracks lives, level,
//            score and the per-life countdown, gates motion and re-spawns
//            the frog in response to start/collision/crossing events.
// Ports    : clk, reset_n       - clock, asynchronous active-low reset
//            refresh_tick       - one-cycle pulse per video frame
//            start_btn          - raw start button (asynchronous)
//            frog_hit, frog_win - one-cycle playfield event pulses
//            state              - FSM state encoding
//            lives, level       - remaining lives, obstacle speed select
//            score              - saturating binary score
//            time_left          - seconds left in the current life
//            motion_en          - frog/obstacle update enable
//            frog_reset         - one-cycle respawn pulse
//            game_over          - high while in GAME_OVER
// Revision : 1.0  initial release
// ============================================================================
module frogger_game_ctrl
    import frogger_pkg::*;
#(
    parameter int TICKS_PER_SEC = c_DEF_TICKS_PER_SEC,
    parameter int TIME_LIMIT    = c_DEF_TIME_LIMIT,
    parameter int START_LIVES   = c_DEF_START_LIVES,
    parameter int DEATH_TICKS   = c_DEF_DEATH_TICKS,
    parameter int LEVELUP_TICKS = c_DEF_LEVELUP_TICKS,
    parameter int MAX_LEVEL     = c_DEF_MAX_LEVEL,
    parameter int CROSS_POINTS  = c_DEF_CROSS_POINTS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 refresh_tick,
    input  logic                 start_btn,
    input  logic                 frog_hit,
    input  logic                 frog_win,
    output logic [c_STATE_W-1:0] state,
    output logic [1:0]           lives,
    output logic [2:0]           level,
    output logic [c_SCORE_W-1:0] score,
    output logic [5:0]           time_left,
    output logic                 motion_en,
    output logic                 frog_reset,
    output logic                 game_over
);

    localparam int c_CNT_W = $clog2(max3(TICKS_PER_SEC, DEATH_TICKS, LEVELUP_TICKS) + 1);

    localparam logic [c_CNT_W-1:0]   c_TICK_LAST  = c_CNT_W'(TICKS_PER_SEC - 1);
    localparam logic [c_CNT_W-1:0]   c_DEATH_LAST = c_CNT_W'(DEATH_TICKS - 1);
    localparam logic [c_CNT_W-1:0]   c_LVL_LAST   = c_CNT_W'(LEVELUP_TICKS - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [5:0]           c_TIME_LIMIT = 6'(TIME_LIMIT);
    localparam logic [1:0]           c_LIVES_INIT = 2'(START_LIVES);
    localparam logic [2:0]           c_MAX_LEVEL  = 3'(MAX_LEVEL);
    localparam logic [c_SCORE_W:0]   c_CROSS      = (c_SCORE_W+1)'(CROSS_POINTS);

    logic [c_STATE_W-1:0] r_state;
    logic [1:0]           r_lives;
    logic [2:0]           r_level;
    logic [c_SCORE_W-1:0] r_score;
    logic [5:0]           r_time_left;
    logic                 r_motion_en;
    logic                 r_frog_reset;
    logic                 r_game_over;
    logic [c_CNT_W-1:0]   r_tick_cnt;
    logic [c_CNT_W-1:0]   r_wait_cnt;

    logic                 w_start_rise;
    logic                 w_sec_wrap;
    logic                 w_timeout;
    logic                 w_hit;
    logic [c_SCORE_W:0]   w_win_sum;
    logic [c_SCORE_W-1:0] w_score_next;
    logic [2:0]           w_level_next;

    btn_edge u_start_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .i_btn   (start_btn),
        .o_rise  (w_start_rise)
    );

    // A second boundary with one second left is the countdown expiring;
    // it is folded into the hit path so it takes priority over a win.
    assign w_sec_wrap = refresh_tick && (r_tick_cnt == c_TICK_LAST);
    assign w_timeout  = w_sec_wrap && (r_time_left <= 6'd1);
    assign w_hit      = frog_hit || w_timeout;

    // One extra bit catches the carry so the score can clamp at all-ones.
    assign w_win_sum    = {1'b0, r_score} + c_CROSS + {{(c_SCORE_W-5){1'b0}}, r_time_left};
    assign w_score_next = w_win_sum[c_SCORE_W] ? {c_SCORE_W{1'b1}} : w_win_sum[c_SCORE_W-1:0];
    assign w_level_next = (r_level >= c_MAX_LEVEL) ? r_level : r_level + 3'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_IDLE;
            r_lives      <= 2'd0;
            r_level      <= 3'd0;
            r_score      <= '0;
            r_time_left  <= 6'd0;
            r_motion_en  <= 1'b0;
            r_frog_reset <= 1'b0;
            r_game_over  <= 1'b0;
            r_tick_cnt   <= '0;
            r_wait_cnt   <= '0;
        end else begin
            // frog_reset is only ever set for the single clk of a transition
            // into PLAY, so clearing it here keeps it a 1-clk pulse.
            r_frog_reset <= 1'b0;

            case (r_state)
                c_ST_IDLE, c_ST_GAME_OVER: begin
                    if (w_start_rise) begin
                        r_lives      <= c_LIVES_INIT;
                        r_level      <= 3'd0;
                        r_score      <= '0;
                        r_time_left  <= c_TIME_LIMIT;
                        r_tick_cnt   <= '0;
                        r_wait_cnt   <= '0;
                        r_frog_reset <= 1'b1;
                        r_motion_en  <= 1'b1;
                        r_game_over  <= 1'b0;
                        r_state      <= c_ST_PLAY;
                    end
                end

                c_ST_PLAY: begin
                    if (refresh_tick) begin
                        if (w_sec_wrap) begin
                            r_tick_cnt <= '0;
                            if (r_time_left != 6'd0) begin
                                r_time_left <= r_time_left - 6'd1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_CNT_ONE;
                        end
                    end

                    if (w_hit) begin
                        if (r_lives != 2'd0) begin
                            r_lives <= r_lives - 2'd1;
                        end
                        r_wait_cnt  <= '0;
                        r_motion_en <= 1'b0;
                        r_state     <= c_ST_DYING;
                    end else if (frog_win) begin
                        r_score     <= w_score_next;
                        r_level     <= w_level_next;
                        r_wait_cnt  <= '0;
                        r_motion_en <= 1'b0;
                        r_state     <= c_ST_LEVEL_UP;
                    end
                end

                c_ST_DYING: begin
                    if (refresh_tick) begin
                        if (r_wait_cnt == c_DEATH_LAST) begin
                            r_wait_cnt <= '0;
                            if (r_lives == 2'd0) begin
                                r_game_over <= 1'b1;
                                r_state     <= c_ST_GAME_OVER;
                            end else begin
                                r_time_left  <= c_TIME_LIMIT;
                                r_tick_cnt   <= '0;
                                r_frog_reset <= 1'b1;
                                r_motion_en  <= 1'b1;
                                r_state      <= c_ST_PLAY;
                            end
                        end else begin
                            r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
                        end
                    end
                end

                c_ST_LEVEL_UP: begin
                    if (refresh_tick) begin
                        if (r_wait_cnt == c_LVL_LAST) begin
                            r_wait_cnt   <= '0;
                            r_time_left  <= c_TIME_LIMIT;
                            r_tick_cnt   <= '0;
                            r_frog_reset <= 1'b1;
                            r_motion_en  <= 1'b1;
                            r_state      <= c_ST_PLAY;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
                        end
                    end
                end

                default: begin
                    r_motion_en <= 1'b0;
                    r_game_over <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign state      = r_state;
    assign lives      = r_lives;
    assign level      = r_level;
    assign score      = r_score;
    assign time_left  = r_time_left;
    assign motion_en  = r_motion_en;
    assign frog_reset = r_frog_reset;
    assign game_over  = r_game_over;

endmodule
`default_nettype wire
